mac_array_west_feeder: RTL and testbench
========================================

# mac_array_west_feeder

Drives the west edge of the MAC tile array: per-row activation/weight nibbles (`out_w`), 2-bit instructions (`inst_w`: bit1 execute, bit0 kernel load), and per-row `zero` flags. It pulls packed row vectors from the L0 buffer over a valid/ready handshake and issues a kernel-load phase of `col` weight vectors followed by an execute phase of `num_act` activation vectors. Row `r` output is skewed by `r` cycles so data enters the array diagonally. It is the transmitter for the tiles' west-side inputs and sits between L0 and array row inputs.

## Interface
- `bw`, 4: element width.
- `row`, 8: array rows (one lane per row).
- `col`, 8: array columns; number of weight vectors per kernel load.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0); clears all state immediately.
- `start` input 1: one-cycle pulse to begin a load+execute pass; ignored unless IDLE.
- `num_act` input 16: activation vectors in execute phase; sampled on accepted `start`.
- `in_data` input row*bw: lane r at bits [r*bw +: bw].
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: feeder accepts `in_data` this cycle.
- `out_w` output row*bw: per-row data to tile column 0 west input.
- `inst_w` output row*2: per-row instruction, lane r at [2r +: 2].
- `zero` output row: per-row zero flag.
- `busy` output 1: pass in progress.
- `done` output 1: one-cycle pulse at end of pass.

## Operation
- FSM: IDLE -> LOAD -> GAP -> EXEC -> DRAIN -> IDLE.
- IDLE: `in_ready`=0; on `start`, latch `num_act`, clear counters, go LOAD.
- LOAD: `in_ready`=1 until `col` vectors accepted. Accepted vector issues with inst=2'b01. Vector k (0-based) is the weight for array column k (column 0 latches first, passes rest east). After `col`th accept -> GAP.
- GAP: one cycle, issues bubble; separates load from execute. -> EXEC, or DRAIN if `num_act`==0.
- EXEC: `in_ready`=1 until `num_act` vectors accepted; each issues with inst=2'b10. After last accept -> DRAIN.
- Bubble (any cycle with no accept, incl. `in_valid`=0 stall in LOAD/EXEC, GAP, DRAIN): data 0, inst 2'b00, zero 1.
- `zero[r]`: EXEC issue: 1 iff lane r data == 0. LOAD issue: 0 always (zero weights must load). Bubble: 1.
- DRAIN: `row` cycles of bubbles at the skew input, flushing the deepest lane; then `done`=1 for one cycle, return IDLE.
- `busy`=1 from cycle after accepted `start` through the `done` cycle inclusive.
- Counters: accept counter 16 bits; no wrap within a pass (max 65535 activations).

## Timing
- Issue stage registered: accept at edge N appears on lane 0 outputs after edge N (cycle N+1).
- Lane r: delay chain of r extra registers; lane r shows accept-N data/inst/zero in cycle N+1+r. Data, inst and zero of a lane always skew together.
- Reset values: `out_w`=0, `inst_w`=0, `zero`=all 1, `in_ready`=0, `busy`=0, `done`=0, state IDLE, all skew registers = bubble.
- Reset mid-pass: outputs go to reset values asynchronously; in-flight skewed data discarded; no `done`.
- `start` while busy: ignored, no effect on `num_act`.
- `in_ready` combinational from state and counter only (never from `in_valid`).
- Throughput: one vector per cycle with `in_valid` held high; pass length = col + 1 + num_act + row + 1 cycles from start to done.

## Test plan
- Reset: hold `reset`=0 mid-EXEC -> all outputs at reset values same cycle; release, IDLE, `in_ready`=0.
- Full pass, row=col=8, num_act=4, `in_valid` always 1: weights 0x1..0x8 in all lanes, inst=01 lane0 cycles 2-9; bubble cycle 10; activations inst=10 cycles 11-14; lane 7 inst=10 cycles 18-21; `done` at cycle 22.
- Skew check: activation vector with lane r = r -> lane r shows value r exactly r cycles after lane 0, inst aligned.
- Zero flags: activation lanes 0,3 = 0, others 5 -> zero=1 on lanes 0,3 only; weight 0 in LOAD -> zero=0, inst=01.
- Stall: drop `in_valid` for 3 cycles in LOAD and EXEC -> 3 bubbles (inst 00, zero 1), no counter advance, pass extends 6 cycles.
- num_act=0 and start-while-busy: pass goes LOAD->GAP->DRAIN, `done` after col+1+row+1 cycles; second `start` during pass ignored.

Source files
------------

// File: rtl/mac_array_west_feeder_if.sv
// L0-to-feeder row-vector handshake: packed lanes plus valid/ready.
interface mac_array_west_feeder_if #(
  parameter int BW  = 4,
  parameter int ROW = 8
);
  logic [ROW*BW-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mac_array_west_feeder.sv
// West-edge feeder for the MAC tile array: pulls a kernel-load then execute sequence
// from L0 and issues it row-skewed so data enters the array diagonally.
module mac_array_west_feeder #(
  parameter int BW  = 4,
  parameter int ROW = 8,
  parameter int COL = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           num_act,
  mac_array_west_feeder_if.slave l0,
  output logic [ROW*BW-1:0]     out_w,
  output logic [ROW*2-1:0]      inst_w,
  output logic [ROW-1:0]        zero,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, EXEC, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       numAct_q, numAct_d;
  logic              done_q, done_d;
  logic              accept;
  logic [ROW*BW-1:0] issData_d;
  logic [1:0]        issInst_d;
  logic [ROW-1:0]    issZero_d;

  assign l0.in_ready = (state_q == LOAD) || (state_q == EXEC);
  assign accept      = l0.in_valid && l0.in_ready;
  assign busy        = (state_q != IDLE) || done_q;
  assign done        = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      numAct_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      numAct_q <= numAct_d;
      done_q   <= done_d;
    end
  end

  // The single counter tracks accepts in LOAD/EXEC and bubble cycles in DRAIN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    numAct_d  = numAct_q;
    done_d    = 1'b0;
    issData_d = '0;
    issInst_d = 2'b00;
    issZero_d = '1;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          numAct_d = num_act;
          cnt_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          issData_d = l0.in_data;
          issInst_d = 2'b01;
          issZero_d = '0;
          if (cnt_q == 16'(COL - 1)) begin
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      GAP: begin
        cnt_d   = '0;
        state_d = (numAct_q == 16'd0) ? DRAIN : EXEC;
      end
      EXEC: begin
        if (accept) begin
          issData_d = l0.in_data;
          issInst_d = 2'b10;
          for (int r = 0; r < ROW; r++) begin
            issZero_d[r] = (l0.in_data[r*BW +: BW] == '0);
          end
          if (cnt_q == numAct_q - 16'd1) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 16'(ROW - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane r carries r+1 stages; stage 0 is the registered issue, the last drives the array.
  for (genvar r = 0; r < ROW; r++) begin : g_lane
    logic [BW-1:0] dChain_q [0:r];
    logic [1:0]    iChain_q [0:r];
    logic          zChain_q [0:r];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int s = 0; s <= r; s++) begin
          dChain_q[s] <= '0;
          iChain_q[s] <= 2'b00;
          zChain_q[s] <= 1'b1;
        end
      end else begin
        dChain_q[0] <= issData_d[r*BW +: BW];
        iChain_q[0] <= issInst_d;
        zChain_q[0] <= issZero_d[r];
        for (int s = 1; s <= r; s++) begin
          dChain_q[s] <= dChain_q[s-1];
          iChain_q[s] <= iChain_q[s-1];
          zChain_q[s] <= zChain_q[s-1];
        end
      end
    end

    assign out_w[r*BW +: BW] = dChain_q[r];
    assign inst_w[2*r +: 2]  = iChain_q[r];
    assign zero[r]           = zChain_q[r];
  end

endmodule

// File: tb/tb_mac_array_west_feeder.sv
// Directed bench for mac_array_west_feeder: per-pass timeline tables of drive and
// expected issue values; each lane's expectation is the issue table delayed by its row.
module tb_mac_array_west_feeder;

  localparam int BW  = 4;
  localparam int ROW = 8;
  localparam int COL = 8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] numAct;
  logic [31:0] outW;
  logic [15:0] instW;
  logic [7:0]  zeroW;
  logic        busy;
  logic        done;

  mac_array_west_feeder_if #(.BW(BW), .ROW(ROW)) l0If ();

  mac_array_west_feeder #(.BW(BW), .ROW(ROW), .COL(COL)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .num_act (numAct),
    .l0      (l0If),
    .out_w   (outW),
    .inst_w  (instW),
    .zero    (zeroW),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFail    = 0;

  logic [31:0] drvData  [64];
  bit          drvValid [64];
  bit          drvStart [64];
  logic [15:0] drvNum   [64];
  logic [31:0] expData  [64];
  logic [1:0]  expInst  [64];
  logic [7:0]  expZero  [64];
  bit          expRdy   [64];
  int          doneCycle;

  function automatic logic [7:0] laneZeros(input logic [31:0] v);
    logic [7:0] z;
    for (int r = 0; r < ROW; r++) z[r] = (v[r*BW +: BW] == 4'h0);
    return z;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearTables(input logic [15:0] n);
    for (int c = 0; c < 64; c++) begin
      drvData[c]  = 32'hFFFF_FFFF;
      drvValid[c] = 1'b1;
      drvStart[c] = 1'b0;
      drvNum[c]   = n;
      expData[c]  = '0;
      expInst[c]  = 2'b00;
      expZero[c]  = 8'hFF;
      expRdy[c]   = 1'b0;
    end
    drvStart[0] = 1'b1;
  endtask

  task automatic addLoad(input int c, input logic [31:0] v);
    drvData[c]   = v;
    expRdy[c]    = 1'b1;
    expData[c+1] = v;
    expInst[c+1] = 2'b01;
    expZero[c+1] = 8'h00;
  endtask

  task automatic addExec(input int c, input logic [31:0] v);
    drvData[c]   = v;
    expRdy[c]    = 1'b1;
    expData[c+1] = v;
    expInst[c+1] = 2'b10;
    expZero[c+1] = laneZeros(v);
  endtask

  task automatic addStall(input int c);
    drvValid[c] = 1'b0;
    drvData[c]  = 32'hDEAD_BEEF;
    expRdy[c]   = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int c);
    start         = drvStart[c];
    numAct        = drvNum[c];
    l0If.in_valid = drvValid[c];
    l0If.in_data  = drvData[c];
  endtask

  task automatic checkOutput(input string pass, input int c);
    logic [31:0] eData;
    logic [15:0] eInst;
    logic [7:0]  eZero;
    eData = '0;
    eInst = '0;
    eZero = '1;
    for (int r = 0; r < ROW; r++) begin
      if (c - r >= 0) begin
        eData[r*BW +: BW] = expData[c-r][r*BW +: BW];
        eInst[2*r +: 2]   = expInst[c-r];
        eZero[r]          = expZero[c-r][r];
      end
    end
    checkEq($sformatf("%s c%0d out_w", pass, c), outW, eData);
    checkEq($sformatf("%s c%0d inst_w", pass, c), {16'h0, instW}, {16'h0, eInst});
    checkEq($sformatf("%s c%0d zero", pass, c), {24'h0, zeroW}, {24'h0, eZero});
    checkEq($sformatf("%s c%0d in_ready", pass, c), {31'h0, l0If.in_ready}, {31'h0, expRdy[c]});
    checkEq($sformatf("%s c%0d busy", pass, c), {31'h0, busy},
            {31'h0, (c >= 1 && c <= doneCycle)});
    checkEq($sformatf("%s c%0d done", pass, c), {31'h0, done}, {31'h0, (c == doneCycle)});
  endtask

  task automatic runCycles(input string pass, input int first, input int last);
    for (int c = first; c <= last; c++) begin
      tick();
      checkOutput(pass, c);
      applyStimulus(c);
    end
  endtask

  task automatic fillBasicPass();
    logic [3:0] nib;
    clearTables(16'd4);
    for (int k = 0; k < COL; k++) begin
      nib = 4'(k + 1);
      addLoad(1 + k, {8{nib}});
    end
    addExec(10, 32'h7654_3210);
    addExec(11, 32'h5555_0550);
    addExec(12, 32'h9999_9999);
    addExec(13, 32'hAAAA_AAAA);
    doneCycle = 22;
  endtask

  initial begin
    logic [3:0] nib;
    reset         = 1'b0;
    start         = 1'b0;
    numAct        = '0;
    l0If.in_valid = 1'b0;
    l0If.in_data  = '0;
    doneCycle     = -1;
    #12;
    checkEq("reset out_w", outW, 32'h0);
    checkEq("reset inst_w", {16'h0, instW}, 32'h0);
    checkEq("reset zero", {24'h0, zeroW}, 32'hFF);
    checkEq("reset in_ready", {31'h0, l0If.in_ready}, 32'h0);
    checkEq("reset busy", {31'h0, busy}, 32'h0);
    checkEq("reset done", {31'h0, done}, 32'h0);
    reset = 1'b1;
    tick();

    // Pass 1: full load+execute, valid always high; skew and zero-flag vectors
    fillBasicPass();
    applyStimulus(0);
    runCycles("basic", 1, doneCycle + 1);

    // Pass 2: zero weight, all-zero activation, 3-cycle stalls in LOAD and EXEC
    clearTables(16'd2);
    addLoad(1, 32'h0000_0000);
    addLoad(2, 32'h1111_1111);
    for (int c = 3; c <= 5; c++) addStall(c);
    for (int k = 2; k < COL; k++) begin
      nib = 4'(k);
      addLoad(4 + k, {8{nib}});
    end
    addExec(13, 32'h0000_0000);
    for (int c = 14; c <= 16; c++) addStall(c);
    addExec(17, 32'h1234_5678);
    doneCycle = 26;
    applyStimulus(0);
    runCycles("stall", 1, doneCycle + 1);

    // Pass 3: num_act=0 with a second start (and new num_act) mid-pass
    clearTables(16'd0);
    for (int k = 0; k < COL; k++) begin
      nib = 4'(15 - k);
      addLoad(1 + k, {8{nib}});
    end
    for (int c = 1; c < 64; c++) drvNum[c] = 16'd5;
    drvStart[4] = 1'b1;
    doneCycle   = 18;
    applyStimulus(0);
    runCycles("noact", 1, doneCycle + 1);

    // Pass 4: asynchronous reset in the middle of EXEC
    fillBasicPass();
    applyStimulus(0);
    runCycles("abort", 1, 11);
    #1;
    reset = 1'b0;
    #1;
    checkEq("async out_w", outW, 32'h0);
    checkEq("async inst_w", {16'h0, instW}, 32'h0);
    checkEq("async zero", {24'h0, zeroW}, 32'hFF);
    checkEq("async in_ready", {31'h0, l0If.in_ready}, 32'h0);
    checkEq("async busy", {31'h0, busy}, 32'h0);
    checkEq("async done", {31'h0, done}, 32'h0);
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    clearTables(16'd4);
    drvStart[0] = 1'b0;
    doneCycle   = -1;
    applyStimulus(0);
    runCycles("postrst", 1, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
